// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Writable 64 x 32-bit instruction RAM with a byte-stream load
//                port. Bytes are assembled big-endian into words and written
//                sequentially from word address 0. The processor is held in
//                reset until a load completes (or run_start releases it).
//
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                a / rd              - processor read address / comb. data
//                load_start          - pulse: load word_count words
//                run_start           - pulse: release processor, no load
//                word_count          - words to load (legal 1..DEPTH)
//                in_valid/in_data    - byte stream in
//                in_ready            - byte accepted when in_valid is high
//                cpu_reset           - processor reset (high unless running)
//                load_done/load_err  - one-cycle status pulses
//                words_loaded        - words written by current/last load
//
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] a,
   output logic [31:0]   rd,
   input  logic          load_start,
   input  logic          run_start,
   input  logic [AW:0]   word_count,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          cpu_reset,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   words_loaded
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];
   localparam logic [AW:0] C_ONE   = {{AW{1'b0}}, 1'b1};

   state_t        r_state;
   state_t        w_state_nxt;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_waddr;
   logic [1:0]    r_byte_cnt;
   logic [23:0]   r_asm;          // bytes 0..2 of the word in progress
   logic [AW:0]   r_word_count;
   logic [AW:0]   r_words_loaded;
   logic          r_load_done;
   logic          r_load_err;

   logic          w_wc_legal;
   logic          w_accept;
   logic          w_word_we;
   logic          w_last_word;
   logic          w_start_load;
   logic          w_err;

   // Datapath qualifiers. Reset gates acceptance so a byte arriving on the
   // reset edge can never complete and write a partial word.
   always_comb begin
      w_wc_legal  = (word_count != '0) && (word_count <= C_DEPTH);
      w_accept    = (r_state == ST_LOAD) && in_valid && !reset;
      w_word_we   = w_accept && (r_byte_cnt == 2'd3);
      w_last_word = w_word_we && ((r_words_loaded + C_ONE) == r_word_count);
   end

   // Next-state and Moore outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_start_load = 1'b0;
      w_err        = 1'b0;
      cpu_reset    = 1'b1;
      in_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // load_start takes priority over run_start
            if (load_start) begin
               if (w_wc_legal) begin
                  w_state_nxt  = ST_LOAD;
                  w_start_load = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end else if (run_start) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (w_last_word) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            cpu_reset = 1'b0;
            if (load_start) begin
               if (w_wc_legal) begin
                  w_state_nxt  = ST_LOAD;
                  w_start_load = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_waddr        <= '0;
         r_byte_cnt     <= '0;
         r_asm          <= '0;
         r_word_count   <= '0;
         r_words_loaded <= '0;
         r_load_done    <= 1'b0;
         r_load_err     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_load_done <= w_last_word;   // high in the first RUN cycle
         r_load_err  <= w_err;
         if (w_start_load) begin
            r_word_count   <= word_count;
            r_waddr        <= '0;
            r_words_loaded <= '0;
            r_byte_cnt     <= '0;
            r_asm          <= '0;
         end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps 3 -> 0
            case (r_byte_cnt)
               2'd0:    r_asm[23:16] <= in_data;
               2'd1:    r_asm[15:8]  <= in_data;
               2'd2:    r_asm[7:0]   <= in_data;
               default: r_asm        <= r_asm;   // byte 3 goes straight to RAM
            endcase
            if (w_word_we) begin
               r_waddr        <= r_waddr + 1'b1;
               r_words_loaded <= r_words_loaded + C_ONE;
            end
         end
      end
   end

   // RAM has no reset: contents survive reset and re-entry to IDLE.
   always_ff @(posedge clk) begin
      if (w_word_we) begin
         r_mem[r_waddr] <= {r_asm, in_data};
      end
   end

   assign rd           = r_mem[a];
   assign load_done    = r_load_done;
   assign load_err     = r_load_err;
   assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Keeps a word-level
//                model of RAM contents plus the expected processor-release
//                status and words_loaded value, and checks the DUT against it
//                under directed and randomized load/run/illegal sequences.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] a;
   logic [31:0]   rd;
   logic          load_start;
   logic          run_start;
   logic [AW:0]   word_count;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          cpu_reset;
   logic          load_done;
   logic          load_err;
   logic [AW:0]   words_loaded;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .a            (a),
      .rd           (rd),
      .load_start   (load_start),
      .run_start    (run_start),
      .word_count   (word_count),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .cpu_reset    (cpu_reset),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   // Reference model
   logic [31:0] model_mem [DEPTH];
   bit          mem_known [DEPTH];
   bit          exp_run;        // processor expected released
   int          exp_wl;         // expected words_loaded
   logic [31:0] ld_words [$];   // words for the next load, in order

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_run));
      check({tag, "_in_ready"},  32'(in_ready), 32'd0);
      check({tag, "_wl"},        32'(words_loaded), 32'(exp_wl));
   endtask

   task automatic check_ram();
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_known[i]) begin
            a = 6'(i);
            @(negedge clk);
            check("ram", rd, model_mem[i]);
         end
      end
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_run = 1'b0;
      exp_wl  = 0;
      check_status("reset");
      check("reset_done", 32'(load_done), 32'd0);
      check("reset_err",  32'(load_err), 32'd0);
   endtask

   task automatic do_run();
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      exp_run = 1'b1;
      check_status("run");
      check("run_done", 32'(load_done), 32'd0);
   endtask

   task automatic do_illegal(input int wc);
      load_start = 1'b1;
      word_count = 7'(wc);
      step();
      load_start = 1'b0;
      check("err_pulse", 32'(load_err), 32'd1);
      check_status("err");
      step();
      check("err_once", 32'(load_err), 32'd0);
      check_status("err_after");
   endtask

   // Load ld_words. gap_mode: 0 = back-to-back bytes, 1 = one idle cycle
   // before every byte, 2 = random 0..2 idle cycles (with random ignored
   // start pulses and word_count noise during the gaps).
   task automatic do_load(input int gap_mode, input bit with_run);
      int          n;
      int          gaps;
      logic [31:0] cur;
      n = ld_words.size();
      load_start = 1'b1;
      run_start  = with_run;
      word_count = 7'(n);
      step();
      load_start = 1'b0;
      run_start  = 1'b0;
      check("start_in_ready",  32'(in_ready), 32'd1);
      check("start_cpu_reset", 32'(cpu_reset), 32'd1);
      check("start_err",       32'(load_err), 32'd0);
      check("start_wl",        32'(words_loaded), 32'd0);
      for (int w = 0; w < n; w++) begin
         cur = ld_words[w];
         for (int k = 0; k < 4; k++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
               in_valid   = 1'b0;
               in_data    = 8'($urandom);
               if (gap_mode == 2) begin
                  load_start = 1'($urandom_range(0, 1));
                  run_start  = 1'($urandom_range(0, 1));
                  word_count = 7'($urandom);
               end
               step();
               load_start = 1'b0;
               run_start  = 1'b0;
               check("gap_in_ready",  32'(in_ready), 32'd1);
               check("gap_cpu_reset", 32'(cpu_reset), 32'd1);
               check("gap_err",       32'(load_err), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = cur[31-8*k -: 8];
            if (k == 3 && mem_known[w]) begin
               a = 6'(w);
               #1;
               check("pre_write_rd", rd, model_mem[w]);
            end
            step();
            in_valid = 1'b0;
            if (k == 3) begin
               model_mem[w] = cur;
               mem_known[w] = 1'b1;
               a = 6'(w);
               #1;
               check("post_write_rd", rd, cur);
               check("word_wl", 32'(words_loaded), 32'(w + 1));
            end
         end
      end
      exp_run = 1'b1;
      exp_wl  = n;
      check("done_pulse", 32'(load_done), 32'd1);
      check_status("done");
      step();
      check("done_once", 32'(load_done), 32'd0);
      check_status("done_after");
   endtask

   initial begin
      logic [63:0] s;
      logic [31:0] w0;
      logic [31:0] w1;

      reset      = 1'b1;
      a          = '0;
      load_start = 1'b0;
      run_start  = 1'b0;
      word_count = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      exp_run    = 1'b0;
      exp_wl     = 0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_known[i] = 1'b0;
         model_mem[i] = '0;
      end
      step();
      do_reset();

      // Fill the whole RAM (largest legal word_count) so every word is known
      ld_words.delete();
      for (int i = 0; i < DEPTH; i++) ld_words.push_back($urandom);
      do_load(2, 1'b0);
      check_ram();

      // Basic two-word load after reset
      do_reset();
      ld_words.delete();
      ld_words.push_back(32'h2002_0005);
      ld_words.push_back(32'h2003_000C);
      do_load(0, 1'b0);
      a = 6'd0; #1; check("tp1_ram0", rd, 32'h2002_0005);
      a = 6'd1; #1; check("tp1_ram1", rd, 32'h2003_000C);

      // Single word with in_valid toggling every other cycle
      do_reset();
      ld_words.delete();
      ld_words.push_back(32'hAABB_CCDD);
      do_load(1, 1'b0);

      // Illegal word counts from IDLE
      do_reset();
      do_illegal(0);
      do_illegal(65);
      do_illegal(127);
      check_ram();

      // Reset after 6 of 8 bytes
      do_reset();
      w0 = $urandom;
      w1 = $urandom;
      s  = {w0, w1};
      load_start = 1'b1;
      word_count = 7'd2;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = s[63-8*i -: 8];
         step();
      end
      in_valid = 1'b0;
      model_mem[0] = w0;
      check("abort_wl_before", 32'(words_loaded), 32'd1);
      do_reset();
      check_ram();
      ld_words.delete();
      ld_words.push_back($urandom);
      do_load(0, 1'b0);

      // run_start from IDLE, then reload from RUN
      do_reset();
      do_run();
      check_ram();
      ld_words.delete();
      ld_words.push_back($urandom);
      do_load(2, 1'b0);
      do_illegal(0);       // illegal from RUN stays RUN

      // load_start and run_start together in IDLE
      do_reset();
      ld_words.delete();
      ld_words.push_back($urandom);
      ld_words.push_back($urandom);
      do_load(0, 1'b1);

      // Randomized operation mix
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 4))
            0: do_illegal(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 127)));
            1: begin
               if (!exp_run) do_run();
            end
            2: do_reset();
            default: begin
               ld_words.delete();
               for (int i = 0; i < int'($urandom_range(1, 8)); i++) ld_words.push_back($urandom);
               do_load(2, 1'($urandom_range(0, 1)));
            end
         endcase
      end
      check_ram();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
